mac_layer_seq: RTL and testbench

//  Sequences the 16-input fixed-point MAC across all neurons of one dense layer.
//  On start, latches the 16-bit input vector. Per neuron it then:
//   - fetches 16 10-bit weights plus one bias from synchronous ROMs;
//   - packs the weights into the 160-bit weight stream and clears the MAC;
//   - waits for the MAC to settle and emits the 10-bit result on a valid/ready stream.

---
 rtl/mac_layer_seq.sv | 148 ++++++++++++++
 tb/tb_mac_layer_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_seq.sv
// Dense-layer sequencer: for each neuron it fetches weights and bias, lets the MAC
// settle, then hands the result downstream on a valid/ready stream.
module mac_layer_seq #(
   parameter int N_IN        = 16,
   parameter int W           = 10,
   parameter int NUM_NEURONS = 8,
   parameter int MAC_LAT     = 1,
   parameter int AW          = 7
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [N_IN-1:0]                in_vec,
   output logic                           busy,
   output logic                           done,
   output logic [AW-1:0]                  w_addr,
   input  logic [W-1:0]                   w_data,
   output logic [$clog2(NUM_NEURONS)-1:0] b_addr,
   input  logic [W-1:0]                   b_data,
   output logic [N_IN-1:0]                mac_in,
   output logic [N_IN*W-1:0]              mac_ws,
   output logic [W-1:0]                   mac_bias,
   output logic                           mac_clr,
   input  logic [W-1:0]                   mac_out,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [W-1:0]                   res_data,
   output logic [$clog2(NUM_NEURONS)-1:0] res_idx
);

   localparam int NW = $clog2(NUM_NEURONS);
   localparam int JW = $clog2(N_IN + 1);
   localparam int LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [JW-1:0] J_LAST   = JW'(N_IN);
   localparam logic [LW-1:0] LAT_LAST = LW'(MAC_LAT - 1);
   localparam logic [NW-1:0] N_LAST   = NW'(NUM_NEURONS - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SETTLE,
      EMIT,
      DONE
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [NW-1:0]       r_neuron;
   logic [JW-1:0]       r_j;
   logic [LW-1:0]       r_lat;
   logic [N_IN-1:0]     r_inVec;
   logic [N_IN*W-1:0]   r_ws;
   logic [W-1:0]        r_bias;
   logic [W-1:0]        r_resData;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FETCH runs one cycle past the last address so the final ROM word can land.
   always_comb begin
      w_nextState = r_state;
      busy        = (r_state != IDLE);
      done        = (r_state == DONE);
      res_valid   = (r_state == EMIT);
      mac_clr     = 1'b0;
      w_addr      = '0;
      b_addr      = '0;
      case (r_state)
         IDLE: begin
            if (start) w_nextState = FETCH;
         end
         FETCH: begin
            if (r_j != J_LAST) w_addr = AW'(r_neuron) * AW'(N_IN) + AW'(r_j);
            if (r_j == '0) begin
               mac_clr = 1'b1;
               b_addr  = r_neuron;
            end
            if (r_j == J_LAST) w_nextState = SETTLE;
         end
         SETTLE: begin
            if (r_lat == LAT_LAST) w_nextState = EMIT;
         end
         EMIT: begin
            if (res_ready) w_nextState = (r_neuron == N_LAST) ? DONE : FETCH;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Untouched weight slots keep the previous neuron's words until overwritten.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_neuron  <= '0;
         r_j       <= '0;
         r_lat     <= '0;
         r_inVec   <= '0;
         r_ws      <= '0;
         r_bias    <= '0;
         r_resData <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_inVec  <= in_vec;
                  r_neuron <= '0;
                  r_j      <= '0;
               end
            end
            FETCH: begin
               if (r_j != '0) r_ws[W*(int'(r_j) - 1) +: W] <= w_data;
               if (r_j == JW'(1)) r_bias <= b_data;
               if (r_j == J_LAST) begin
                  r_j   <= '0;
                  r_lat <= '0;
               end else begin
                  r_j <= r_j + JW'(1);
               end
            end
            SETTLE: begin
               if (r_lat == LAT_LAST) r_resData <= mac_out;
               else                   r_lat     <= r_lat + LW'(1);
            end
            EMIT: begin
               if (res_ready && (r_neuron != N_LAST)) r_neuron <= r_neuron + NW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign mac_in   = r_inVec;
   assign mac_ws   = r_ws;
   assign mac_bias = r_bias;
   assign res_data = r_resData;
   assign res_idx  = r_neuron;

endmodule

// File: tb/tb_mac_layer_seq.sv
// Bench for mac_layer_seq: ROM and MAC stubs around a MAC_LAT=1 and a MAC_LAT=3 instance,
// with expected results derived from the ROM contents by plain arithmetic.
module tb_mac_layer_seq;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          start2;
   logic          resReady;
   logic [15:0]   inVec;

   logic          busy, done, macClr, resValid;
   logic [6:0]    wAddr;
   logic [2:0]    bAddr, resIdx;
   logic [9:0]    wData, bData, macBias, macOut, resData;
   logic [15:0]   macIn;
   logic [159:0]  macWs;

   logic          busy2, done2, macClr2, resValid2;
   logic [6:0]    wAddr2;
   logic [2:0]    bAddr2, resIdx2;
   logic [9:0]    wData2, bData2, macBias2, macOut2, resData2;
   logic [15:0]   macIn2;
   logic [159:0]  macWs2;
   logic [9:0]    d1, d2;

   logic [9:0]    romW [128];
   logic [9:0]    romB [8];

   int nCmp  = 0;
   int nFail = 0;
   int cyc   = 0;
   int hsCyc[$], hsIdx[$], hsData[$], doneCyc[$];
   int hs2Cyc[$], hs2Idx[$], hs2Data[$], done2Cyc[$];

   always #5 clk = ~clk;

   mac_layer_seq #(.MAC_LAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_vec(inVec),
      .busy(busy), .done(done), .w_addr(wAddr), .w_data(wData),
      .b_addr(bAddr), .b_data(bData), .mac_in(macIn), .mac_ws(macWs),
      .mac_bias(macBias), .mac_clr(macClr), .mac_out(macOut),
      .res_valid(resValid), .res_ready(resReady), .res_data(resData), .res_idx(resIdx)
   );

   mac_layer_seq #(.MAC_LAT(3)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .in_vec(inVec),
      .busy(busy2), .done(done2), .w_addr(wAddr2), .w_data(wData2),
      .b_addr(bAddr2), .b_data(bData2), .mac_in(macIn2), .mac_ws(macWs2),
      .mac_bias(macBias2), .mac_clr(macClr2), .mac_out(macOut2),
      .res_valid(resValid2), .res_ready(1'b1), .res_data(resData2), .res_idx(resIdx2)
   );

   function automatic logic [9:0] wsSum(input logic [159:0] ws, input logic [9:0] b);
      int s = int'(b);
      for (int k = 0; k < 16; k++) s += int'(ws[10*k +: 10]);
      return 10'(s % 1024);
   endfunction

   // Synchronous ROMs: one cycle of read latency
   always @(posedge clk) begin
      wData  <= romW[wAddr];
      bData  <= romB[bAddr];
      wData2 <= romW[wAddr2];
      bData2 <= romB[bAddr2];
   end

   // MAC stubs: instant for the first instance, two-register delay for MAC_LAT=3
   always_comb macOut = wsSum(macWs, macBias);
   always @(posedge clk) begin
      d1 <= wsSum(macWs2, macBias2);
      d2 <= d1;
   end
   assign macOut2 = d2;

   // Stream monitor on the falling edge, well clear of stimulus at posedge+2
   always @(negedge clk) begin
      if (resValid && resReady) begin
         hsCyc.push_back(cyc);
         hsIdx.push_back(int'(resIdx));
         hsData.push_back(int'(resData));
      end
      if (done) doneCyc.push_back(cyc);
      if (resValid2) begin
         hs2Cyc.push_back(cyc);
         hs2Idx.push_back(int'(resIdx2));
         hs2Data.push_back(int'(resData2));
      end
      if (done2) done2Cyc.push_back(cyc);
      cyc++;
   end

   function automatic logic [159:0] expWs(input int n);
      logic [159:0] r = '0;
      for (int k = 0; k < 16; k++) r[10*k +: 10] = romW[n*16 + k];
      return r;
   endfunction

   function automatic logic [9:0] expRes(input int n);
      int s = int'(romB[n]);
      for (int k = 0; k < 16; k++) s += int'(romW[n*16 + k]);
      return 10'(s % 1024);
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] v);
      inVec = v;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic waitUntilValid(input string tag);
      int k = 0;
      while (!resValid && k < 60) begin
         step();
         k++;
      end
      checkOutput({tag, " valid"}, 160'(resValid), 160'(1));
   endtask

   task automatic clearLogs();
      hsCyc.delete(); hsIdx.delete(); hsData.delete(); doneCyc.delete();
      hs2Cyc.delete(); hs2Idx.delete(); hs2Data.delete(); done2Cyc.delete();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " busy"},     160'(busy),     160'(0));
      checkOutput({tag, " done"},     160'(done),     160'(0));
      checkOutput({tag, " resValid"}, 160'(resValid), 160'(0));
      checkOutput({tag, " macWs"},    macWs,          160'(0));
      checkOutput({tag, " macBias"},  160'(macBias),  160'(0));
      checkOutput({tag, " resData"},  160'(resData),  160'(0));
      checkOutput({tag, " macIn"},    160'(macIn),    160'(0));
      checkOutput({tag, " macClr"},   160'(macClr),   160'(0));
      checkOutput({tag, " wAddr"},    160'(wAddr),    160'(0));
      checkOutput({tag, " bAddr"},    160'(bAddr),    160'(0));
      checkOutput({tag, " resIdx"},   160'(resIdx),   160'(0));
   endtask

   initial begin
      int k;
      logic [15:0] v;
      reset_n  = 1'b0;
      start    = 1'b0;
      start2   = 1'b0;
      resReady = 1'b1;
      inVec    = 16'h0;
      for (int a = 0; a < 128; a++) romW[a] = 10'(a);
      for (int n = 0; n < 8; n++)   romB[n] = 10'(n + 5);
      step(3);
      checkAllZero("reset");

      // Abort in the middle of neuron 3's fetch
      reset_n = 1'b1;
      applyStimulus(16'($urandom));
      k = 0;
      while (wAddr != 7'd53 && k < 200) begin
         step();
         k++;
      end
      checkOutput("reach n3 fetch", 160'(wAddr), 160'(53));
      reset_n = 1'b0;
      step(2);
      checkAllZero("midreset");
      checkOutput("midreset no done", 160'(doneCyc.size()), 160'(0));
      reset_n = 1'b1;
      step();
      clearLogs();

      // Full layer with address-valued ROM and ready held high
      applyStimulus(16'hFFFF);
      checkOutput("n0 j0 macClr", 160'(macClr), 160'(1));
      checkOutput("n0 j0 bAddr",  160'(bAddr),  160'(0));
      checkOutput("n0 j0 busy",   160'(busy),   160'(1));
      checkOutput("n0 j0 wAddr",  160'(wAddr),  160'(0));
      inVec = 16'($urandom);
      for (int j = 1; j < 16; j++) begin
         step();
         start = (j == 5);
         checkOutput($sformatf("n0 wAddr j%0d", j), 160'(wAddr), 160'(j));
      end
      start = 1'b0;
      waitUntilValid("n0");
      checkOutput("n0 macWs",   macWs,            expWs(0));
      checkOutput("n0 macBias", 160'(macBias),    160'(5));
      checkOutput("n0 macIn",   160'(macIn),      160'(16'hFFFF));
      checkOutput("n0 resData", 160'(resData),    160'(expRes(0)));
      checkOutput("n0 resIdx",  160'(resIdx),     160'(0));
      k = 0;
      while (!done && k < 300) begin
         step();
         k++;
      end
      checkOutput("layer1 done", 160'(done), 160'(1));
      checkOutput("layer1 done busy", 160'(busy), 160'(1));
      step();
      checkOutput("layer1 idle busy", 160'(busy), 160'(0));
      checkOutput("layer1 idle done", 160'(done), 160'(0));
      checkOutput("layer1 count", 160'(hsCyc.size()), 160'(8));
      for (int i = 0; i < hsCyc.size() && i < 8; i++) begin
         checkOutput($sformatf("layer1 idx%0d", i),  160'(hsIdx[i]),  160'(i));
         checkOutput($sformatf("layer1 data%0d", i), 160'(hsData[i]), 160'(expRes(i)));
         if (i > 0)
            checkOutput($sformatf("layer1 gap%0d", i), 160'(hsCyc[i] - hsCyc[i-1]), 160'(19));
      end
      checkOutput("layer1 done pulses", 160'(doneCyc.size()), 160'(1));
      if (doneCyc.size() > 0 && hsCyc.size() > 0)
         checkOutput("layer1 done timing", 160'(doneCyc[0]), 160'(hsCyc[hsCyc.size()-1] + 1));
      clearLogs();

      // Random ROM, random backpressure, long stall on neuron 2
      for (int a = 0; a < 128; a++) romW[a] = 10'($urandom);
      for (int n = 0; n < 8; n++)   romB[n] = 10'($urandom);
      v = 16'($urandom);
      applyStimulus(v);
      inVec = ~v;
      for (int n = 0; n < 8; n++) begin
         waitUntilValid($sformatf("r n%0d", n));
         checkOutput($sformatf("r n%0d idx", n),  160'(resIdx),  160'(n));
         checkOutput($sformatf("r n%0d data", n), 160'(resData), 160'(expRes(n)));
         checkOutput($sformatf("r n%0d ws", n),   macWs,         expWs(n));
         checkOutput($sformatf("r n%0d bias", n), 160'(macBias), 160'(romB[n]));
         checkOutput($sformatf("r n%0d in", n),   160'(macIn),   160'(v));
         if (n == 2) begin
            resReady = 1'b0;
            for (int s = 0; s < 5; s++) begin
               step();
               checkOutput("stall valid",  160'(resValid), 160'(1));
               checkOutput("stall data",   160'(resData),  160'(expRes(2)));
               checkOutput("stall idx",    160'(resIdx),   160'(2));
               checkOutput("stall macClr", 160'(macClr),   160'(0));
            end
         end else begin
            resReady = 1'b0;
            step($urandom_range(0, 3));
         end
         resReady = 1'b1;
         step();
         if (n == 7) begin
            checkOutput("r done", 160'(done), 160'(1));
            checkOutput("r done busy", 160'(busy), 160'(1));
            start = 1'b1;
            inVec = 16'($urandom);
            step();
            start = 1'b0;
            checkOutput("r start in done ignored", 160'(busy), 160'(0));
            step(2);
            checkOutput("r still idle", 160'(busy), 160'(0));
         end else begin
            checkOutput($sformatf("r n%0d next clr", n), 160'(macClr), 160'(1));
            checkOutput($sformatf("r n%0d next addr", n), 160'(wAddr), 160'((n + 1) * 16));
         end
      end
      checkOutput("r done pulses", 160'(doneCyc.size()), 160'(1));
      clearLogs();

      // MAC_LAT=3 instance: later capture and a 21-cycle neuron period
      v = 16'($urandom);
      inVec  = v;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      inVec  = ~v;
      checkOutput("lat3 j0 macClr", 160'(macClr2), 160'(1));
      k = 0;
      while (!done2 && k < 400) begin
         step();
         k++;
      end
      checkOutput("lat3 done", 160'(done2), 160'(1));
      checkOutput("lat3 macIn", 160'(macIn2), 160'(v));
      step();
      checkOutput("lat3 idle busy", 160'(busy2), 160'(0));
      checkOutput("lat3 count", 160'(hs2Cyc.size()), 160'(8));
      for (int i = 0; i < hs2Cyc.size() && i < 8; i++) begin
         checkOutput($sformatf("lat3 idx%0d", i),  160'(hs2Idx[i]),  160'(i));
         checkOutput($sformatf("lat3 data%0d", i), 160'(hs2Data[i]), 160'(expRes(i)));
         if (i > 0)
            checkOutput($sformatf("lat3 gap%0d", i), 160'(hs2Cyc[i] - hs2Cyc[i-1]), 160'(21));
      end
      if (done2Cyc.size() > 0 && hs2Cyc.size() > 0)
         checkOutput("lat3 done timing", 160'(done2Cyc[0]), 160'(hs2Cyc[hs2Cyc.size()-1] + 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
